// File: rtl/mac_unit_multi.sv
// Multi-lane pipelined multiply-accumulate row segment: 3-stage datapath with double-buffered weights.
// Optional clamping of the stage-3 result (and the sat_flag port) is enabled by defining MAC_SATURATION_EN.
module mac_unit_multi #(
  parameter int LANES             = 4,
  parameter int DATA_WIDTH        = 9,
  parameter int WEIGHT_WIDTH      = 9,
  parameter int LAST_SUM_WIDTH    = 0,
  parameter int PARTIAL_SUM_WIDTH = 20
) (
  input  logic                                                        clk,
  input  logic                                                        rst,
  input  logic                                                        enable,
  input  logic                                                        signed_mode,
  input  logic [LANES*WEIGHT_WIDTH-1:0]                               weight_in,
  input  logic                                                        preload_weight,
  input  logic                                                        load_weight,
  input  logic [LANES*DATA_WIDTH-1:0]                                 data_in,
  input  logic                                                        valid_in,
  input  logic                                                        acc_mode,
  input  logic                                                        acc_clear,
  input  logic [LANES*((LAST_SUM_WIDTH > 0) ? LAST_SUM_WIDTH : 1)-1:0] last_sum,
  output logic                                                        valid_out,
  output logic [LANES*PARTIAL_SUM_WIDTH-1:0]                          partial_sum
`ifdef MAC_SATURATION_EN
  ,
  output logic [LANES-1:0]                                            sat_flag
`endif
);

  localparam int DW  = DATA_WIDTH;
  localparam int WW  = WEIGHT_WIDTH;
  localparam int PW  = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int PSW = PARTIAL_SUM_WIDTH;
  localparam int LSW = (LAST_SUM_WIDTH > 0) ? LAST_SUM_WIDTH : 1;
`ifdef MAC_SATURATION_EN
  // Two guard bits so the pre-clamp sum never overflows in either mode
  localparam int EW = PSW + 2;
  localparam logic signed [EW-1:0] SMAX = EW'({1'b0, {(PSW-1){1'b1}}});
  localparam logic signed [EW-1:0] SMIN = ~SMAX;
  localparam logic signed [EW-1:0] UMAX = EW'({PSW{1'b1}});
`else
  localparam int EW = PSW;
`endif

  if (PSW < PW || PSW < LAST_SUM_WIDTH) begin : g_bad_width
    $error("mac_unit_multi: PARTIAL_SUM_WIDTH too small for product or last_sum");
  end

  logic [LANES*WW-1:0]  preweight_q, preweight_d, weight_q, weight_d;
  logic [LANES*DW-1:0]  s1_data_q, s1_data_d;
  logic                 s1_valid_q, s1_valid_d, s1_signed_q, s1_signed_d;
  logic                 s1_acc_q, s1_acc_d, s1_clr_q, s1_clr_d;
  logic [LANES*PW-1:0]  s2_prod_q, s2_prod_d;
  logic                 s2_valid_q, s2_valid_d, s2_signed_q, s2_signed_d;
  logic                 s2_acc_q, s2_acc_d, s2_clr_q, s2_clr_d;
  logic [LANES*PSW-1:0] psum_q, psum_d;
  logic                 vout_q, vout_d;
`ifdef MAC_SATURATION_EN
  logic [LANES-1:0]     sat_q, sat_d;
`endif

  logic [PW-1:0]        a_w, b_w;
  logic signed [EW-1:0] prod_e, base_e, sum_e;

  always_comb begin
    preweight_d = preweight_q;
    weight_d    = weight_q;
    if (preload_weight) preweight_d = weight_in;
    else                preweight_d = preweight_q;
    // A simultaneous load takes the buffer contents from before this edge
    if (load_weight) weight_d = preweight_q;
    else             weight_d = weight_q;
  end

  always_comb begin
    s1_data_d   = s1_data_q;
    s1_valid_d  = s1_valid_q;
    s1_signed_d = s1_signed_q;
    s1_acc_d    = s1_acc_q;
    s1_clr_d    = s1_clr_q;
    s2_prod_d   = s2_prod_q;
    s2_valid_d  = s2_valid_q;
    s2_signed_d = s2_signed_q;
    s2_acc_d    = s2_acc_q;
    s2_clr_d    = s2_clr_q;
    a_w         = '0;
    b_w         = '0;
    if (enable) begin
      s1_data_d   = data_in;
      s1_valid_d  = valid_in;
      s1_signed_d = signed_mode;
      s1_acc_d    = acc_mode;
      s1_clr_d    = acc_clear;
      s2_valid_d  = s1_valid_q;
      s2_signed_d = s1_signed_q;
      s2_acc_d    = s1_acc_q;
      s2_clr_d    = s1_clr_q;
      for (int l = 0; l < LANES; l++) begin
        if (s1_signed_q) begin
          a_w = PW'($signed(s1_data_q[l*DW +: DW]));
          b_w = PW'($signed(weight_q[l*WW +: WW]));
        end else begin
          a_w = PW'(s1_data_q[l*DW +: DW]);
          b_w = PW'(weight_q[l*WW +: WW]);
        end
        s2_prod_d[l*PW +: PW] = a_w * b_w;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  always_comb begin
    psum_d = psum_q;
    vout_d = vout_q;
`ifdef MAC_SATURATION_EN
    sat_d  = sat_q;
`endif
    prod_e = '0;
    base_e = '0;
    sum_e  = '0;
    if (enable) begin
      vout_d = s2_valid_q;
      if (s2_valid_q) begin
        for (int l = 0; l < LANES; l++) begin
          if (s2_signed_q) prod_e = EW'($signed(s2_prod_q[l*PW +: PW]));
          else             prod_e = EW'(s2_prod_q[l*PW +: PW]);
          if (s2_acc_q) begin
            if (s2_clr_q)         base_e = '0;
            else if (s2_signed_q) base_e = EW'($signed(psum_q[l*PSW +: PSW]));
            else                  base_e = EW'(psum_q[l*PSW +: PSW]);
          end else if (LAST_SUM_WIDTH > 0) begin
            if (s2_signed_q) base_e = EW'($signed(last_sum[l*LSW +: LSW]));
            else             base_e = EW'(last_sum[l*LSW +: LSW]);
          end else begin
            base_e = '0;
          end
          sum_e = prod_e + base_e;
`ifdef MAC_SATURATION_EN
          sat_d[l]              = 1'b0;
          psum_d[l*PSW +: PSW]  = sum_e[PSW-1:0];
          if (s2_signed_q) begin
            if (sum_e > SMAX) begin
              psum_d[l*PSW +: PSW] = SMAX[PSW-1:0];
              sat_d[l]             = 1'b1;
            end else if (sum_e < SMIN) begin
              psum_d[l*PSW +: PSW] = SMIN[PSW-1:0];
              sat_d[l]             = 1'b1;
            end else begin
              sat_d[l] = 1'b0;
            end
          end else if (sum_e > UMAX) begin
            psum_d[l*PSW +: PSW] = UMAX[PSW-1:0];
            sat_d[l]             = 1'b1;
          end else begin
            sat_d[l] = 1'b0;
          end
`else
          psum_d[l*PSW +: PSW] = sum_e;
`endif
        end
      end else begin
        psum_d = psum_q;
      end
    end else begin
      vout_d = vout_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      preweight_q <= '0;
      weight_q    <= '0;
      s1_data_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_signed_q <= 1'b0;
      s1_acc_q    <= 1'b0;
      s1_clr_q    <= 1'b0;
      s2_prod_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_signed_q <= 1'b0;
      s2_acc_q    <= 1'b0;
      s2_clr_q    <= 1'b0;
      psum_q      <= '0;
      vout_q      <= 1'b0;
`ifdef MAC_SATURATION_EN
      sat_q       <= '0;
`endif
    end else begin
      preweight_q <= preweight_d;
      weight_q    <= weight_d;
      s1_data_q   <= s1_data_d;
      s1_valid_q  <= s1_valid_d;
      s1_signed_q <= s1_signed_d;
      s1_acc_q    <= s1_acc_d;
      s1_clr_q    <= s1_clr_d;
      s2_prod_q   <= s2_prod_d;
      s2_valid_q  <= s2_valid_d;
      s2_signed_q <= s2_signed_d;
      s2_acc_q    <= s2_acc_d;
      s2_clr_q    <= s2_clr_d;
      psum_q      <= psum_d;
      vout_q      <= vout_d;
`ifdef MAC_SATURATION_EN
      sat_q       <= sat_d;
`endif
    end
  end

  assign partial_sum = psum_q;
  assign valid_out   = vout_q;
`ifdef MAC_SATURATION_EN
  assign sat_flag    = sat_q;
`endif

endmodule

// File: tb/tb_mac_unit_multi.sv
// Randomized and directed bench for mac_unit_multi: one instance with an upstream sum input,
// one top-row instance (LAST_SUM_WIDTH=0), both checked against an integer reference model.
module tb_mac_unit_multi;
  localparam int L = 4, DW = 9, WW = 9, LSW = 16, PSW = 20;

  logic clk = 1'b0;
  logic rst = 1'b0, enable = 1'b1, signed_mode = 1'b0;
  logic preload_weight = 1'b0, load_weight = 1'b0;
  logic valid_in = 1'b0, acc_mode = 1'b0, acc_clear = 1'b0;
  logic [L*WW-1:0]  weight_in = '0;
  logic [L*DW-1:0]  data_in   = '0;
  logic [L*LSW-1:0] last_sum  = '0;
  logic [L-1:0]     last_sum0 = '0;
  logic             valid_out, valid_out0;
  logic [L*PSW-1:0] partial_sum, partial_sum0;
`ifdef MAC_SATURATION_EN
  logic [L-1:0]     sat_flag, sat_flag0;
`endif

  always #5 clk = ~clk;

  mac_unit_multi #(.LANES(L), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW),
                   .LAST_SUM_WIDTH(LSW), .PARTIAL_SUM_WIDTH(PSW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .signed_mode(signed_mode),
    .weight_in(weight_in), .preload_weight(preload_weight), .load_weight(load_weight),
    .data_in(data_in), .valid_in(valid_in), .acc_mode(acc_mode), .acc_clear(acc_clear),
    .last_sum(last_sum), .valid_out(valid_out), .partial_sum(partial_sum)
`ifdef MAC_SATURATION_EN
    , .sat_flag(sat_flag)
`endif
  );

  mac_unit_multi #(.LANES(L), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW),
                   .LAST_SUM_WIDTH(0), .PARTIAL_SUM_WIDTH(PSW)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .signed_mode(signed_mode),
    .weight_in(weight_in), .preload_weight(preload_weight), .load_weight(load_weight),
    .data_in(data_in), .valid_in(valid_in), .acc_mode(acc_mode), .acc_clear(acc_clear),
    .last_sum(last_sum0), .valid_out(valid_out0), .partial_sum(partial_sum0)
`ifdef MAC_SATURATION_EN
    , .sat_flag(sat_flag0)
`endif
  );

  int n_tests = 0, n_fail = 0;

  // Reference model state: weights, samples in flight, expected outputs
  int unsigned m_pre[L], m_act[L], s1_d[L];
  bit          s1_v, s1_sgn, s1_acc, s1_clr, s2_v, s2_sgn, s2_acc, s2_clr;
  longint      s2_p[L], e_ps[L], e_ps0[L];
  bit [L-1:0]  e_sat, e_sat0;
  bit          e_vo;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint sval(input longint v, input int w, input bit sgn);
    longint m, x;
    m = longint'(1) << w;
    x = v & (m - 1);
    if (sgn && x >= (m >> 1)) x = x - m;
    return x;
  endfunction

  task automatic stage3(input longint prev, input longint prod, input longint lastv,
                        input bit sgn, input bit acc, input bit clr, input bit use_last,
                        output longint res, output bit sat);
    longint t;
    t = prod;
    if (acc) begin
      if (!clr) t += sval(prev, PSW, sgn);
    end else if (use_last) begin
      t += sval(lastv, LSW, sgn);
    end
    sat = 1'b0;
`ifdef MAC_SATURATION_EN
    begin
      longint lo, hi;
      lo = sgn ? -(longint'(1) << (PSW - 1)) : 0;
      hi = sgn ? (longint'(1) << (PSW - 1)) - 1 : (longint'(1) << PSW) - 1;
      if (t > hi) begin t = hi; sat = 1'b1; end
      else if (t < lo) begin t = lo; sat = 1'b1; end
    end
`endif
    res = t & ((longint'(1) << PSW) - 1);
  endtask

  task automatic model_edge();
    longint r;
    bit s;
    int unsigned old;
    if (!rst) begin
      for (int l = 0; l < L; l++) begin
        m_pre[l] = 0; m_act[l] = 0; s1_d[l] = 0; s2_p[l] = 0; e_ps[l] = 0; e_ps0[l] = 0;
      end
      {s1_v, s1_sgn, s1_acc, s1_clr, s2_v, s2_sgn, s2_acc, s2_clr} = '0;
      e_sat = '0; e_sat0 = '0; e_vo = 1'b0;
    end else begin
      if (enable) begin
        e_vo = s2_v;
        if (s2_v) begin
          for (int l = 0; l < L; l++) begin
            stage3(e_ps[l], s2_p[l], longint'(last_sum[l*LSW +: LSW]), s2_sgn, s2_acc, s2_clr, 1'b1, r, s);
            e_ps[l] = r; e_sat[l] = s;
            stage3(e_ps0[l], s2_p[l], 0, s2_sgn, s2_acc, s2_clr, 1'b0, r, s);
            e_ps0[l] = r; e_sat0[l] = s;
          end
        end
        {s2_v, s2_sgn, s2_acc, s2_clr} = {s1_v, s1_sgn, s1_acc, s1_clr};
        for (int l = 0; l < L; l++)
          s2_p[l] = sval(s1_d[l], DW, s1_sgn) * sval(m_act[l], WW, s1_sgn);
        {s1_v, s1_sgn, s1_acc, s1_clr} = {valid_in, signed_mode, acc_mode, acc_clear};
        for (int l = 0; l < L; l++) s1_d[l] = data_in[l*DW +: DW];
      end
      for (int l = 0; l < L; l++) begin
        old = m_pre[l];
        if (preload_weight) m_pre[l] = weight_in[l*WW +: WW];
        if (load_weight)    m_act[l] = old;
      end
    end
  endtask

  task automatic compare_all();
    logic [L*PSW-1:0] ev, ev0;
    for (int l = 0; l < L; l++) begin
      ev[l*PSW +: PSW]  = e_ps[l][PSW-1:0];
      ev0[l*PSW +: PSW] = e_ps0[l][PSW-1:0];
    end
    check("valid_out", valid_out, e_vo);
    check("valid_out_top", valid_out0, e_vo);
    check("psum", partial_sum, ev);
    check("psum_top", partial_sum0, ev0);
`ifdef MAC_SATURATION_EN
    check("sat_flag", sat_flag, e_sat);
    check("sat_flag_top", sat_flag0, e_sat0);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic issue(input int d, input bit sgn, input bit acc, input bit clr, input int ls);
    data_in     = {L{d[DW-1:0]}};
    last_sum    = {L{ls[LSW-1:0]}};
    last_sum0   = 4'($urandom);
    signed_mode = sgn; acc_mode = acc; acc_clear = clr;
    valid_in    = 1'b1;
    tick();
    valid_in    = 1'b0;
  endtask

  task automatic load_w(input int w);
    weight_in = {L{w[WW-1:0]}};
    preload_weight = 1'b1; tick();
    preload_weight = 1'b0; load_weight = 1'b1; tick();
    load_weight = 1'b0;
  endtask

  initial begin
    // Reset held while a valid sample is presented
    valid_in = 1'b1; data_in = {L{9'd7}};
    tick(); check("rst_vo_c1", valid_out, 1'b0); check("rst_psum_c1", partial_sum, '0);
    tick(); check("rst_vo_c2", valid_out, 1'b0); check("rst_psum_c2", partial_sum0, '0);
    rst = 1'b1; data_in = {L{9'd3}};
    tick(); check("lat_c1", valid_out, 1'b0);
    valid_in = 1'b0;
    tick(); check("lat_c2", valid_out, 1'b0);
    tick(); check("lat_c3", valid_out, 1'b1);
    tick(); tick();

    // Unsigned, plain add
    load_w(5);
    issue(7, 1'b0, 1'b0, 1'b0, 0); tick(); tick();
    check("t2_psum_top", partial_sum0, {L{20'd35}});
    check("t2_psum", partial_sum, {L{20'd35}});
    check("t2_vo", valid_out0, 1'b1);

    // Signed vs unsigned with upstream sum
    load_w(9'h1FD);
    issue(100, 1'b1, 1'b0, 1'b0, 10); tick(); tick();
    check("t3_signed", partial_sum[PSW-1:0], 20'hFFEDE);
    check("t3_signed_top", partial_sum0[PSW-1:0], 20'hFFED4);
    issue(100, 1'b0, 1'b0, 1'b0, 10); tick(); tick();
    check("t3_unsigned", partial_sum[PSW-1:0], 20'd50910);
    check("t3_unsigned_top", partial_sum0[PSW-1:0], 20'd50900);

    // Local accumulation, back to back
    load_w(10);
    issue(2, 1'b0, 1'b1, 1'b1, 0);
    issue(3, 1'b0, 1'b1, 1'b0, 0);
    issue(4, 1'b0, 1'b1, 1'b0, 0);
    check("t4_acc1", partial_sum[PSW-1:0], 20'd20);
    tick(); check("t4_acc2", partial_sum[PSW-1:0], 20'd50);
    tick(); check("t4_acc3", partial_sum[PSW-1:0], 20'd90);
    issue(1, 1'b0, 1'b1, 1'b1, 0); tick(); tick();
    check("t4_clear", partial_sum[PSW-1:0], 20'd10);

    // Stall mid-stream, then a bubble
    issue(5, 1'b0, 1'b0, 1'b0, 0);
    enable = 1'b0;
    tick(); tick();
    check("t5_stall_psum", partial_sum[PSW-1:0], 20'd10);
    check("t5_stall_vo", valid_out, 1'b0);
    enable = 1'b1;
    tick(); tick();
    check("t5_resume_psum", partial_sum[PSW-1:0], 20'd50);
    check("t5_resume_vo", valid_out, 1'b1);
    tick();
    check("t5_bubble_psum", partial_sum[PSW-1:0], 20'd50);
    check("t5_bubble_vo", valid_out, 1'b0);

    // Simultaneous preload and load
    weight_in = {L{9'd4}}; preload_weight = 1'b1; tick();
    weight_in = {L{9'd9}}; load_weight = 1'b1; tick();
    preload_weight = 1'b0; load_weight = 1'b0;
    issue(1, 1'b0, 1'b0, 1'b0, 0); tick(); tick();
    check("t5_old_preweight", partial_sum[PSW-1:0], 20'd4);
    load_weight = 1'b1; tick(); load_weight = 1'b0;
    issue(1, 1'b0, 1'b0, 1'b0, 0); tick(); tick();
    check("t5_new_preweight", partial_sum[PSW-1:0], 20'd9);

    // Signed accumulation of 255*255 past the positive limit
    load_w(255);
    issue(255, 1'b1, 1'b1, 1'b1, 0);
    for (int i = 0; i < 9; i++) issue(255, 1'b1, 1'b1, 1'b0, 0);
    tick(); tick();
`ifdef MAC_SATURATION_EN
    check("t6_sat", partial_sum[PSW-1:0], 20'd524287);
    check("t6_sat_flag", sat_flag, 4'hF);
`else
    check("t6_wrap", partial_sum[PSW-1:0], 20'd650250);
    check("t6_wrap_top", partial_sum0[PSW-1:0], 20'd650250);
`endif

    // Random traffic with occasional resets and stalls
    for (int c = 0; c < 400; c++) begin
      rst            = ($urandom_range(0, 49) != 0);
      enable         = ($urandom_range(0, 3) != 0);
      signed_mode    = 1'($urandom);
      preload_weight = ($urandom_range(0, 3) == 0);
      load_weight    = ($urandom_range(0, 3) == 0);
      valid_in       = ($urandom_range(0, 3) != 0);
      acc_mode       = 1'($urandom);
      acc_clear      = ($urandom_range(0, 3) == 0);
      weight_in      = 36'({$urandom, $urandom});
      data_in        = 36'({$urandom, $urandom});
      last_sum       = {$urandom, $urandom};
      last_sum0      = 4'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
